// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: sequential integer ALU with an iterative multiply/divide unit.
//   Simple RV32I/RV64I ALU ops finish one cycle after acceptance. MUL/MULHU
//   (shift-add) and DIV/DIVU/REM/REMU (restoring divide) take XLEN
//   iterations. Handshake: an op is accepted when in_valid && in_ready.
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   in_valid/ready   request handshake (ready low while iterating)
//   alu_op[3:0]      operation select
//   src_a, src_b     operands, captured on the accepting edge
//   done             one-cycle strobe, result/zero/sign valid
//   result,zero,sign registered outputs, held between done pulses
module alu_mdu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            sign
);

  localparam logic [3:0] OP_ADD  = 4'b0000, OP_SLL  = 4'b0001, OP_SUB  = 4'b0010,
                         OP_SLT  = 4'b0011, OP_XOR  = 4'b0100, OP_SRL  = 4'b0101,
                         OP_OR   = 4'b0110, OP_AND  = 4'b0111, OP_SRA  = 4'b1000,
                         OP_SLTU = 4'b1001, OP_MUL  = 4'b1010, OP_MULH = 4'b1011,
                         OP_DIVU = 4'b1100, OP_REMU = 4'b1101, OP_DIV  = 4'b1110,
                         OP_REM  = 4'b1111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;      // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q, acc_d;        // {hi, lo}: product, or {remainder, quotient}
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d, sign_q, sign_d;

  logic              accept, long_op, sdiv, is_mul;
  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   alu_res, a_mag, b_mag;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, calc_nxt;
  logic [XLEN-1:0]   quo, rem, fin;

  assign in_ready = (state_q != CALC);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign zero     = zero_q;
  assign sign     = sign_q;

  assign accept  = in_valid && in_ready;
  assign long_op = (alu_op >= OP_MUL);
  assign sdiv    = (alu_op == OP_DIV) || (alu_op == OP_REM);
  assign shamt   = src_b[SHW-1:0];
  assign a_mag   = (sdiv && src_a[XLEN-1]) ? -src_a : src_a;
  assign b_mag   = (sdiv && src_b[XLEN-1]) ? -src_b : src_b;

  // Single-cycle operations, computed straight from the inputs.
  always_comb begin
    alu_res = '0;
    case (alu_op)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SLL:  alu_res = src_a << shamt;
      OP_SUB:  alu_res = src_a - src_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_SRL:  alu_res = src_a >> shamt;
      OP_OR:   alu_res = src_a | src_b;
      OP_AND:  alu_res = src_a & src_b;
      OP_SRA:  alu_res = $unsigned($signed(src_a) >>> shamt);
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: add multiplicand into the high half when the
  // current multiplier bit (acc[0]) is set, then shift right with carry.
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_nxt = {mul_sum, acc_q[XLEN-1:1]};

  // One restoring-divide step: shift the next dividend bit into the
  // remainder, subtract when it fits, shift the quotient bit in at the bottom.
  assign div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff = div_sh - {1'b0, opnd_q};
  assign div_ge   = ~div_diff[XLEN];
  assign div_nxt  = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]),
                     acc_q[XLEN-2:0], div_ge};

  assign is_mul   = (op_q == OP_MUL) || (op_q == OP_MULH);
  assign calc_nxt = is_mul ? mul_nxt : div_nxt;
  assign quo      = calc_nxt[XLEN-1:0];
  assign rem      = calc_nxt[2*XLEN-1:XLEN];

  // Final value after the last iteration, with sign fix-up and the
  // divide-by-zero results. Signed overflow falls out of the magnitude path.
  always_comb begin
    fin = '0;
    case (op_q)
      OP_MUL:  fin = calc_nxt[XLEN-1:0];
      OP_MULH: fin = calc_nxt[2*XLEN-1:XLEN];
      OP_DIVU: fin = (b_q == '0) ? '1 : quo;
      OP_REMU: fin = (b_q == '0) ? a_q : rem;
      OP_DIV:  fin = (b_q == '0) ? '1 : ((a_q[XLEN-1] ^ b_q[XLEN-1]) ? -quo : quo);
      OP_REM:  fin = (b_q == '0) ? a_q : (a_q[XLEN-1] ? -rem : rem);
      default: fin = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
    sign_d   = sign_q;
    case (state_q)
      CALC: begin
        acc_d = calc_nxt;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = fin;
          zero_d   = (fin == '0);
          sign_d   = fin[XLEN-1];
        end
      end
      default: begin  // IDLE and DONE both accept
        state_d = IDLE;
        if (accept) begin
          op_d = alu_op;
          a_d  = src_a;
          b_d  = src_b;
          if (long_op) begin
            state_d = CALC;
            cnt_d   = SHW'(XLEN-1);
            if ((alu_op == OP_MUL) || (alu_op == OP_MULH)) begin
              opnd_d = src_a;
              acc_d  = {{XLEN{1'b0}}, src_b};
            end else begin
              opnd_d = b_mag;
              acc_d  = {{XLEN{1'b0}}, a_mag};
            end
          end else begin
            state_d  = DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            sign_d   = alu_res[XLEN-1];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
    end
  end

endmodule
